tt_um_ksa_operand_sequencer: RTL and testbench
==============================================

TT_UM_KSA_OPERAND_SEQUENCER -- requirements
Module: tt_um_ksa_operand_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  clock enable: low = all state holds; outputs unchanged.
REQ-005 ui_in  input  8  operand byte bus.
REQ-006 uio_in  input  8  [0]=wr byte strobe, [1]=rd result-byte toggle, [2]=clr abort; [7:3] ignored.
REQ-007 uo_out  output  8  result byte selected by sel; 0 outside DONE.
REQ-008 uio_out  output  8  [2:0]=0, [3]=busy, [4]=done, [5]=cout, [6]=ovf (signed 16-bit overflow), [7]=sel.
REQ-009 uio_oe  output  8  constant 8'b1111_1000.

Function
REQ-010 Block SHALL be the operand-sequencing stage feeding an internal 8-bit Kogge-Stone adder (generate/propagate, 3 prefix levels, carry-in), performing one 16-bit A+B as two 8-bit passes.
REQ-011 FSM states: IDLE, LD_A1, LD_B0, LD_B1, ADD0, ADD1, DONE; all strobes SHALL be level-sampled at clk edges with ena=1.
REQ-012 IDLE: wr=1 -> capture A[7:0]=ui_in, go LD_A1; else stay.
REQ-013 LD_A1: wr=1 -> A[15:8]=ui_in, go LD_B0; LD_B0: wr -> B[7:0], go LD_B1; LD_B1: wr -> B[15:8], go ADD0; wr=0 holds state.
REQ-014 ADD0 (unconditional, 1 cycle): sum_lo = A[7:0]+B[7:0]+0; carry register = adder cout; go ADD1.
REQ-015 ADD1 (unconditional, 1 cycle): sum_hi = A[15:8]+B[15:8]+carry; cout = adder cout; ovf = (A[15]==B[15]) && (sum_hi[7]!=A[15]); sel=0; go DONE.
REQ-016 Latency: done SHALL assert on the 2nd clk edge after the edge capturing B[15:8].
REQ-017 DONE: uo_out = sel ? sum_hi : sum_lo; rd=1 toggles sel each cycle it is sampled high.
REQ-018 DONE with wr=1: capture A[7:0], clear done/sel, go LD_A1 (back-to-back transactions, no idle cycle); wr has priority over rd.
REQ-019 busy SHALL be 1 in LD_A1, LD_B0, LD_B1, ADD0, ADD1; 0 in IDLE and DONE.
REQ-020 done SHALL be 1 only in DONE; cout/ovf hold last result until next ADD1 or reset.
REQ-021 clr=1 (any state) SHALL go IDLE next edge, clear done/sel, leave cout/ovf/sums untouched; clr has priority over wr and rd.
REQ-022 wr/rd in ADD0/ADD1 SHALL be ignored; rd outside DONE ignored.
REQ-023 Arithmetic modulo 2^16; carry out of bit 15 reported only via cout.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, A=B=sums=0, carry=cout=ovf=done=sel=0, uo_out=0, busy=0.
REQ-025 Reset asserted mid-transaction SHALL discard all captured bytes; first wr after release captures A[7:0].
REQ-026 Reset release SHALL be synchronous-safe: no state change on the releasing edge other than normal IDLE sampling.

Verification
REQ-027 Load A=0x00FF, B=0x0001 -> done 2 cycles after last wr, uo_out=0x00 (sel=0), rd -> uo_out=0x01, cout=0, ovf=0.
REQ-028 A=0xFFFF, B=0x0001 -> sum 0x0000, cout=1, ovf=0; A=0x7FFF, B=0x0001 -> sum 0x8000, cout=0, ovf=1.
REQ-029 wr gaps (wr low 3 cycles between each byte) -> state holds, same result as contiguous load; busy=1 throughout load.
REQ-030 clr asserted in LD_B0 -> IDLE next edge, busy=0, done=0; new 4-byte load computes correctly.
REQ-031 rst_n pulsed low in ADD0 -> all outputs 0 immediately, IDLE after release.
REQ-032 Random 16-bit A,B (>=1000 transactions, back-to-back via DONE wr) -> {sum_hi,sum_lo,cout} equals A+B reference every time.

Source files
------------

// File: rtl/tt_um_ksa_operand_sequencer.sv
// Operand sequencer for a 16-bit add done as two 8-bit passes through an internal
// Kogge-Stone adder. Bytes arrive one per wr strobe; results are read back a byte at a time.
module tt_um_ksa_operand_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_A1 = 3'd1,
    LD_B0 = 3'd2,
    LD_B1 = 3'd3,
    ADD0  = 3'd4,
    ADD1  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [7:0]  sum_lo;
  logic [7:0]  sum_hi;
  logic        carry;
  logic        cout;
  logic        ovf;
  logic        sel;

  logic wr;
  logic rd;
  logic clr;
  logic busy;
  logic done;
  logic unused_uio;

  assign wr         = uio_in[0];
  assign rd         = uio_in[1];
  assign clr        = uio_in[2];
  assign unused_uio = &{1'b0, uio_in[7:3]};

  // Adder operands: low bytes with zero carry-in in ADD0, high bytes with the saved carry otherwise.
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;

  always_comb begin
    add_a   = (state == ADD0) ? a_q[7:0] : a_q[15:8];
    add_b   = (state == ADD0) ? b_q[7:0] : b_q[15:8];
    add_cin = (state == ADD0) ? 1'b0 : carry;
  end

  // Kogge-Stone prefix tree: group generate/propagate over spans 1, 2, 4.
  logic [7:0] gl;
  logic [7:0] pl;
  logic [7:0] gp;
  logic [7:0] pp;
  logic [8:0] c;

  always_comb begin
    gl = add_a & add_b;
    pl = add_a ^ add_b;
    gp = '0;
    pp = '0;
    for (int lvl = 0; lvl < 3; lvl++) begin
      gp = gl;
      pp = pl;
      for (int i = 0; i < 8; i++) begin
        if (i >= (1 << lvl)) begin
          gl[i] = gp[i] | (pp[i] & gp[i - (1 << lvl)]);
          pl[i] = pp[i] & pp[i - (1 << lvl)];
        end
      end
    end
    c[0] = add_cin;
    for (int i = 0; i < 8; i++) begin
      c[i + 1] = gl[i] | (pl[i] & add_cin);
    end
    add_sum  = (add_a ^ add_b) ^ c[7:0];
    add_cout = c[8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_lo <= '0;
      sum_hi <= '0;
      carry  <= 1'b0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      sel    <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        state <= IDLE;
        sel   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (wr) begin
            a_q[7:0] <= ui_in;
            state    <= LD_A1;
          end
          LD_A1: if (wr) begin
            a_q[15:8] <= ui_in;
            state     <= LD_B0;
          end
          LD_B0: if (wr) begin
            b_q[7:0] <= ui_in;
            state    <= LD_B1;
          end
          LD_B1: if (wr) begin
            b_q[15:8] <= ui_in;
            state     <= ADD0;
          end
          ADD0: begin
            sum_lo <= add_sum;
            carry  <= add_cout;
            state  <= ADD1;
          end
          ADD1: begin
            sum_hi <= add_sum;
            cout   <= add_cout;
            ovf    <= (a_q[15] == b_q[15]) && (add_sum[7] != a_q[15]);
            sel    <= 1'b0;
            state  <= DONE;
          end
          DONE: begin
            if (wr) begin
              a_q[7:0] <= ui_in;
              sel      <= 1'b0;
              state    <= LD_A1;
            end else if (rd) begin
              sel <= ~sel;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy    = (state == LD_A1) || (state == LD_B0) || (state == LD_B1) ||
                   (state == ADD0)  || (state == ADD1);
  assign done    = (state == DONE);
  assign uo_out  = done ? (sel ? sum_hi : sum_lo) : 8'h00;
  assign uio_out = {sel, ovf, cout, done, busy, 3'b000};
  assign uio_oe  = 8'b1111_1000;

endmodule

// File: tb/tb_tt_um_ksa_operand_sequencer.sv
// Directed and random 16-bit add transactions; a monitor reassembles each result
// from the two result bytes and checks it against an expected queue.
module tb_tt_um_ksa_operand_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic wr;
  logic rd;
  logic clr;

  assign uio_in = {5'b0, clr, rd, wr};

  tt_um_ksa_operand_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  wire busy  = uio_out[3];
  wire done  = uio_out[4];
  wire cout  = uio_out[5];
  wire ovf   = uio_out[6];
  wire sel   = uio_out[7];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {sum[15:0], cout, ovf}
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: low byte while sel=0, then full result once sel flips to 1
  logic       lo_seen = 1'b0;
  logic [7:0] lo_val  = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done && !sel) begin
        lo_seen = 1'b1;
        lo_val  = uo_out;
      end else if (done && sel && lo_seen) begin
        lo_seen = 1'b0;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", {14'b0, uo_out, lo_val, cout, ovf}, 32'hFFFF_FFFF);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          check("sb_result", {14'b0, uo_out, lo_val, cout, ovf}, {14'b0, e});
        end
      end
    end
  end

  // driver tasks
  task automatic write_byte(input logic [7:0] v);
    wr    = 1'b1;
    ui_in = v;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                         input int gap, input bit ena_gap);
    logic [16:0] s;
    logic [7:0]  bytes [4];
    s = {1'b0, a} + {1'b0, b};
    exp_q.push_back({s[15:0], s[16], (a[15] == b[15]) && (s[15] != a[15])});
    bytes[0] = a[7:0];
    bytes[1] = a[15:8];
    bytes[2] = b[7:0];
    bytes[3] = b[15:8];
    for (int k = 0; k < 4; k++) begin
      write_byte(bytes[k]);
      if (k < 3) begin
        for (int g = 0; g < gap; g++) begin
          if (ena_gap) begin
            ena   = 1'b0;
            wr    = 1'b1;
            ui_in = 8'hEE;
          end
          @(negedge clk);
          ena = 1'b1;
          wr  = 1'b0;
          check("busy_in_gap", {31'b0, busy}, 32'd1);
        end
      end
    end
    check("add0_busy", {30'b0, busy, done}, 32'b10);
    @(negedge clk);
    check("add1_busy", {30'b0, busy, done}, 32'b10);
    @(negedge clk);
    check("done_latency", {30'b0, busy, done}, 32'b01);
    if (!done) begin
      for (int t = 0; t < 8 && !done; t++) @(negedge clk);
      if (!done) check("done_timeout", 32'd0, 32'd1);
    end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = 8'h00;
    wr    = 1'b0;
    rd    = 1'b0;
    clr   = 1'b0;
    #1;
    check("rst_uo_out", {24'b0, uo_out}, 32'h0);
    check("rst_uio_out", {24'b0, uio_out}, 32'h0);
    check("uio_oe", {24'b0, uio_oe}, 32'hF8);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {30'b0, busy, done}, 32'b00);

    run_txn(16'h00FF, 16'h0001, 0, 1'b0);
    run_txn(16'hFFFF, 16'h0001, 0, 1'b0);
    run_txn(16'h7FFF, 16'h0001, 0, 1'b0);
    run_txn(16'h1234, 16'h4321, 3, 1'b0);
    run_txn(16'h8000, 16'h8000, 2, 1'b1);

    // abort in LD_B0; previous result flags (cout=1, ovf=1) must survive
    write_byte(8'h11);
    write_byte(8'h22);
    clr = 1'b1;
    wr  = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wr  = 1'b0;
    check("clr_idle", {30'b0, busy, done}, 32'b00);
    check("clr_keeps_flags", {30'b0, cout, ovf}, 32'b11);
    run_txn(16'h0F0F, 16'hF0F1, 1, 1'b0);

    // reset pulse while in ADD0
    write_byte(8'hAB);
    write_byte(8'hCD);
    write_byte(8'h01);
    write_byte(8'h02);
    check("pre_rst_add0", {30'b0, busy, done}, 32'b10);
    rst_n = 1'b0;
    #1;
    check("midrst_uo_out", {24'b0, uo_out}, 32'h0);
    check("midrst_uio_out", {24'b0, uio_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_midrst", {30'b0, busy, done}, 32'b00);
    run_txn(16'h0001, 16'h0002, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      run_txn(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
